// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package mux_arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int HC_W    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so PTR sits at
// bit 0, take the lowest set bit, then add PTR back to get the real index.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;

    assign dbl = {req, req} >> ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot[gi] = dbl[gi];
        end
    endgenerate

    // Scan downwards so the lowest set bit is the one left standing.
    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign found  = |req;
    assign winner = off + ptr;
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 8-way address/data mux select, with an
// optional hold limit that preempts an owner keeping the mux too long.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] GNT,
    output logic [IDX_W-1:0]   SEL,
    output logic               BUSY,
    output logic               PREEMPT
);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD);

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0]   sel_reg, sel_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [HC_W-1:0]    hc_reg, hc_next;
    logic               busy_reg, busy_next;
    logic               preempt_reg, preempt_next;

    logic               is_own;
    logic               owner_req;
    logic               timeout;
    logic               release_own;
    logic               preempt_rel;
    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [IDX_W-1:0]   winner;

    assign is_own      = (state_reg == ST_OWN);
    assign owner_req   = REQ[sel_reg];
    assign timeout     = (MAX_HOLD != 0) && (hc_reg == HOLD_LIM);
    assign release_own = is_own && (!owner_req || timeout);
    // A drop that coincides with the timeout is an ordinary release.
    assign preempt_rel = is_own && owner_req && timeout;
    assign others      = REQ & ~gnt_reg;
    // A preempted owner only re-wins when nobody else is asking.
    assign cand        = (preempt_rel && (|others)) ? others : REQ;

    rr_pick u_pick (
        .req    (cand),
        .ptr    (ptr_reg),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        sel_next     = sel_reg;
        ptr_next     = ptr_reg;
        hc_next      = hc_reg;
        busy_next    = busy_reg;
        preempt_next = preempt_rel;
        if (!is_own || release_own) begin
            if (found) begin
                state_next = ST_OWN;
                gnt_next   = NUM_REQ'(1) << winner;
                sel_next   = winner;
                ptr_next   = winner + IDX_W'(1);
                hc_next    = HC_W'(1);
                busy_next  = 1'b1;
            end else begin
                state_next = ST_IDLE;
                gnt_next   = '0;
                hc_next    = '0;
                busy_next  = 1'b0;
            end
        end else if (hc_reg != '1) begin
            hc_next = hc_reg + HC_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= '0;
            sel_reg     <= '0;
            ptr_reg     <= '0;
            hc_reg      <= '0;
            busy_reg    <= 1'b0;
            preempt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            sel_reg     <= sel_next;
            ptr_reg     <= ptr_next;
            hc_reg      <= hc_next;
            busy_reg    <= busy_next;
            preempt_reg <= preempt_next;
        end
    end

    assign GNT     = gnt_reg;
    assign SEL     = sel_reg;
    assign BUSY    = busy_reg;
    assign PREEMPT = preempt_reg;
endmodule
